// File: rtl/ipv4_checksum_stream_if.sv
// AXI-Stream bundle shared by the checksum engine's data input and result output.
interface AXIS_int #(
    parameter int unsigned DATALEN = 8,
    parameter int unsigned USERLEN = 2
);
    logic [DATALEN-1:0]   tdata;
    logic [DATALEN/8-1:0] tkeep;
    logic [USERLEN-1:0]   tuser;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport Master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport Slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/ipv4_checksum_stream.sv
// Streaming RFC 1071 checksum: beat word-sum, per-packet accumulate, fold, FWFT result FIFO.
// Define IPV4_CHECKSUM_STATS_EN to add the pkt_count/bad_count statistics ports.
module ipv4_checksum_stream #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MAX_BYTES  = 20,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    AXIS_int.Slave  s_axis,
    AXIS_int.Master m_axis_csum
`ifdef IPV4_CHECKSUM_STATS_EN
    ,
    output logic [31:0] pkt_count,
    output logic [31:0] bad_count
`endif
);
    localparam int unsigned NumWords = DATA_BYTES / 2;
    localparam int unsigned PartW    = 16 + $clog2(NumWords);
    localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = AddrW + 1;
    localparam logic [17:0] MaxB     = 18'(MAX_BYTES);

    logic             ready_en_q;
    logic [16:0]      off_q;
    logic             s1_valid_q, s1_last_q, s1_runt_q;
    logic [PartW-1:0] s1_sum_q;
    logic [31:0]      acc_q, fin_q, acc_sum;
    logic             fin_valid_q, fin_runt_q;
    logic             res_valid_q;
    logic [17:0]      res_q;
    logic [17:0]      mem_q [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             accept, pop;
    logic [7:0]       occupancy;
    logic [PartW-1:0] beat_sum;
    logic [16:0]      off_next;
    logic             beat_runt;
    logic [16:0]      fold1;
    logic [15:0]      fold;
    logic             unused_in;

    assign unused_in = ^s_axis.tuser;

    // In-flight tlast beats reserve FIFO slots so a push can never find it full.
    assign occupancy     = 8'(cnt_q) + 8'(s1_last_q) + 8'(fin_valid_q) + 8'(res_valid_q);
    assign s_axis.tready = ready_en_q && (occupancy < 8'(FIFO_DEPTH));
    assign accept        = s_axis.tvalid && s_axis.tready;

    always_comb begin
        logic [7:0]  byte_v [DATA_BYTES];
        logic [7:0]  nkeep;
        logic [17:0] boff;
        logic [17:0] end_off;
        beat_sum = '0;
        nkeep    = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            boff      = {1'b0, off_q} + 18'(k);
            byte_v[k] = s_axis.tkeep[DATA_BYTES-1-k] ? s_axis.tdata[8*(DATA_BYTES-k)-1 -: 8] : 8'h00;
            if (MAX_BYTES != 0 && boff >= MaxB) byte_v[k] = 8'h00;
            if (s_axis.tkeep[DATA_BYTES-1-k]) nkeep = nkeep + 8'd1;
        end
        for (int w = 0; w < NumWords; w++) begin
            beat_sum = beat_sum + PartW'({byte_v[2*w], byte_v[2*w+1]});
        end
        end_off   = {1'b0, off_q} + 18'(nkeep);
        off_next  = end_off[17] ? 17'h1FFFF : end_off[16:0];
        beat_runt = (MAX_BYTES != 0) && ({1'b0, off_next} < MaxB);
    end

    assign acc_sum = acc_q + 32'(s1_sum_q);

    always_comb begin
        fold1 = {1'b0, fin_q[31:16]} + {1'b0, fin_q[15:0]};
        fold  = fold1[15:0] + {15'h0, fold1[16]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q  <= 1'b0;
            off_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_runt_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            fin_q       <= '0;
            fin_valid_q <= 1'b0;
            fin_runt_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            s1_valid_q  <= accept;
            s1_last_q   <= accept && s_axis.tlast;
            if (accept) begin
                s1_sum_q  <= beat_sum;
                s1_runt_q <= beat_runt;
                off_q     <= s_axis.tlast ? '0 : off_next;
            end
            fin_valid_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                acc_q      <= s1_last_q ? '0 : acc_sum;
                fin_q      <= acc_sum;
                fin_runt_q <= s1_runt_q;
            end
            res_valid_q <= fin_valid_q;
            if (fin_valid_q) res_q <= {fin_runt_q, fold == 16'hFFFF, ~fold};
        end
    end

    assign pop = m_axis_csum.tvalid && m_axis_csum.tready;

    always_ff @(posedge clk) begin
        if (res_valid_q) mem_q[wr_ptr_q] <= res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (res_valid_q) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)         rd_ptr_q <= rd_ptr_q + 1'b1;
            if (res_valid_q && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!res_valid_q && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Output gated while empty so the stream shows zeros rather than stale entries.
    assign m_axis_csum.tvalid = (cnt_q != '0);
    assign m_axis_csum.tdata  = m_axis_csum.tvalid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
    assign m_axis_csum.tuser  = m_axis_csum.tvalid ? mem_q[rd_ptr_q][17:16] : 2'b00;
    assign m_axis_csum.tkeep  = '1;
    assign m_axis_csum.tlast  = 1'b1;

`ifdef IPV4_CHECKSUM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
            bad_count <= '0;
        end else if (res_valid_q) begin
            if (pkt_count != 32'hFFFF_FFFF) pkt_count <= pkt_count + 32'd1;
            if (!res_q[16] && bad_count != 32'hFFFF_FFFF) bad_count <= bad_count + 32'd1;
        end
    end
`endif
endmodule
